// File: rtl/watch_mode_ctrl_if.sv
// Button, handshake and display bundle between the watch front panel,
// the mode controller and the downstream clock block.
interface watch_mode_ctrl_if;
  logic       mode_btn;
  logic       set_btn;
  logic       setting_done;
  logic       mode_pulse;
  logic       set_pulse;
  logic       normal_mode_en;
  logic       setting_mode_en;
  logic       alarm_mode_en;
  logic       stopwatch_mode_en;
  logic       sw_running;
  logic [2:0] sw_tens_min;
  logic [3:0] sw_units_min;
  logic [2:0] sw_tens_sec;
  logic [3:0] sw_units_sec;

  // Panel / clock-block side: supplies buttons and setting_done.
  modport master (
    output mode_btn, set_btn, setting_done,
    input  mode_pulse, set_pulse, normal_mode_en, setting_mode_en,
           alarm_mode_en, stopwatch_mode_en, sw_running,
           sw_tens_min, sw_units_min, sw_tens_sec, sw_units_sec
  );

  // Mode controller side.
  modport slave (
    input  mode_btn, set_btn, setting_done,
    output mode_pulse, set_pulse, normal_mode_en, setting_mode_en,
           alarm_mode_en, stopwatch_mode_en, sw_running,
           sw_tens_min, sw_units_min, sw_tens_sec, sw_units_sec
  );
endinterface

// File: rtl/watch_mode_ctrl.sv
// Watch mode controller: button edge detection, NORMAL/SET_TIME/SET_ALARM/
// STOPWATCH sequencing with the clock block's setting_done handshake, and
// the BCD MM:SS stopwatch counter.
module watch_mode_ctrl #(
  parameter int unsigned SW_MAX_MIN = 59
) (
  input  logic              clk,
  input  logic              rst,
  watch_mode_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_NORMAL    = 2'd0;
  localparam logic [1:0] ST_SET_TIME  = 2'd1;
  localparam logic [1:0] ST_SET_ALARM = 2'd2;
  localparam logic [1:0] ST_STOPWATCH = 2'd3;

  localparam logic [2:0] MAX_TENS_MIN  = 3'(SW_MAX_MIN / 10);
  localparam logic [3:0] MAX_UNITS_MIN = 4'(SW_MAX_MIN % 10);

  logic       armed_q;
  logic       mode_q, set_q;
  logic       mode_pulse_q, set_pulse_q;
  logic [1:0] state_q, state_d;
  logic       mask_q;
  logic       normal_en_q, setting_en_q, alarm_en_q, stopwatch_en_q;
  logic       sw_running_q, sw_running_d;
  logic [2:0] tens_min_q, tens_min_d, tens_sec_q, tens_sec_d;
  logic [3:0] units_min_q, units_min_d, units_sec_q, units_sec_d;
  logic [2:0] inc_tens_min, inc_tens_sec;
  logic [3:0] inc_units_min, inc_units_sec;

  // Button history and rising-edge pulses; the first clock after reset only
  // loads the history so a button held through reset never pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q      <= 1'b0;
      mode_q       <= 1'b0;
      set_q        <= 1'b0;
      mode_pulse_q <= 1'b0;
      set_pulse_q  <= 1'b0;
    end else begin
      armed_q      <= 1'b1;
      mode_q       <= bus.mode_btn;
      set_q        <= bus.set_btn;
      mode_pulse_q <= armed_q & bus.mode_btn & ~mode_q;
      set_pulse_q  <= armed_q & bus.set_btn & ~set_q;
    end
  end

  // Mode sequencing; setting_done is ignored on the masked first cycle of
  // an entry state because it is still high from the previous pass.
  always_comb begin
    state_d = state_q;
    if (mode_pulse_q) begin
      case (state_q)
        ST_NORMAL:    state_d = ST_SET_TIME;
        ST_SET_TIME:  if (bus.setting_done && !mask_q) state_d = ST_SET_ALARM;
        ST_SET_ALARM: if (bus.setting_done && !mask_q) state_d = ST_STOPWATCH;
        default:      state_d = ST_NORMAL;
      endcase
    end
  end

  // State, entry mask and enables; enables decode the next state so they
  // change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_NORMAL;
      mask_q         <= 1'b0;
      normal_en_q    <= 1'b1;
      setting_en_q   <= 1'b0;
      alarm_en_q     <= 1'b0;
      stopwatch_en_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mask_q         <= (state_d != state_q) &&
                        ((state_d == ST_SET_TIME) || (state_d == ST_SET_ALARM));
      normal_en_q    <= (state_d == ST_NORMAL) || (state_d == ST_STOPWATCH);
      setting_en_q   <= (state_d == ST_SET_TIME);
      alarm_en_q     <= (state_d == ST_SET_ALARM);
      stopwatch_en_q <= (state_d == ST_STOPWATCH);
    end
  end

  // One-second BCD increment with wrap to 00:00 after SW_MAX_MIN:59.
  always_comb begin
    inc_units_sec = units_sec_q + 4'd1;
    inc_tens_sec  = tens_sec_q;
    inc_units_min = units_min_q;
    inc_tens_min  = tens_min_q;
    if (units_sec_q == 4'd9) begin
      inc_units_sec = 4'd0;
      inc_tens_sec  = tens_sec_q + 3'd1;
      if (tens_sec_q == 3'd5) begin
        inc_tens_sec  = 3'd0;
        inc_units_min = units_min_q + 4'd1;
        if (units_min_q == 4'd9) begin
          inc_units_min = 4'd0;
          inc_tens_min  = tens_min_q + 3'd1;
        end
        if ((tens_min_q == MAX_TENS_MIN) && (units_min_q == MAX_UNITS_MIN)) begin
          inc_units_min = 4'd0;
          inc_tens_min  = 3'd0;
        end
      end
    end
  end

  // Stopwatch control: clear on entry, set toggles run/stop while staying,
  // running counts every cycle, leaving stops it and the digits freeze.
  always_comb begin
    sw_running_d = sw_running_q;
    tens_min_d   = tens_min_q;
    units_min_d  = units_min_q;
    tens_sec_d   = tens_sec_q;
    units_sec_d  = units_sec_q;
    if (sw_running_q) begin
      tens_min_d  = inc_tens_min;
      units_min_d = inc_units_min;
      tens_sec_d  = inc_tens_sec;
      units_sec_d = inc_units_sec;
    end
    if (state_d == ST_STOPWATCH && state_q != ST_STOPWATCH) begin
      sw_running_d = 1'b0;
      tens_min_d   = 3'd0;
      units_min_d  = 4'd0;
      tens_sec_d   = 3'd0;
      units_sec_d  = 4'd0;
    end else if (state_d != ST_STOPWATCH) begin
      sw_running_d = 1'b0;
    end else if (set_pulse_q && !mode_pulse_q) begin
      sw_running_d = ~sw_running_q;
    end
  end

  // Stopwatch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_running_q <= 1'b0;
      tens_min_q   <= 3'd0;
      units_min_q  <= 4'd0;
      tens_sec_q   <= 3'd0;
      units_sec_q  <= 4'd0;
    end else begin
      sw_running_q <= sw_running_d;
      tens_min_q   <= tens_min_d;
      units_min_q  <= units_min_d;
      tens_sec_q   <= tens_sec_d;
      units_sec_q  <= units_sec_d;
    end
  end

  assign bus.mode_pulse        = mode_pulse_q;
  assign bus.set_pulse         = set_pulse_q;
  assign bus.normal_mode_en    = normal_en_q;
  assign bus.setting_mode_en   = setting_en_q;
  assign bus.alarm_mode_en     = alarm_en_q;
  assign bus.stopwatch_mode_en = stopwatch_en_q;
  assign bus.sw_running        = sw_running_q;
  assign bus.sw_tens_min       = tens_min_q;
  assign bus.sw_units_min      = units_min_q;
  assign bus.sw_tens_sec       = tens_sec_q;
  assign bus.sw_units_sec      = units_sec_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl: two instances (SW_MAX_MIN 59 and 1)
// share one stimulus stream; expected values are hand-computed.
module tb_watch_mode_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic mode_btn, set_btn, setting_done;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  watch_mode_ctrl_if bus1 ();
  watch_mode_ctrl_if bus2 ();

  assign bus1.mode_btn     = mode_btn;
  assign bus1.set_btn      = set_btn;
  assign bus1.setting_done = setting_done;
  assign bus2.mode_btn     = mode_btn;
  assign bus2.set_btn      = set_btn;
  assign bus2.setting_done = setting_done;

  watch_mode_ctrl #(.SW_MAX_MIN(59)) dut (.clk(clk), .rst(rst), .bus(bus1));
  watch_mode_ctrl #(.SW_MAX_MIN(1))  dut_short (.clk(clk), .rst(rst), .bus(bus2));

  // {normal, setting, alarm, stopwatch}
  logic [3:0]  en1;
  // digits packed as 16'hMMSS
  logic [15:0] d1, d2;
  assign en1 = {bus1.normal_mode_en, bus1.setting_mode_en, bus1.alarm_mode_en, bus1.stopwatch_mode_en};
  assign d1  = {1'b0, bus1.sw_tens_min, bus1.sw_units_min, 1'b0, bus1.sw_tens_sec, bus1.sw_units_sec};
  assign d2  = {1'b0, bus2.sw_tens_min, bus2.sw_units_min, 1'b0, bus2.sw_tens_sec, bus2.sw_units_sec};

  // Called at a negedge: buttons are sampled high at the next posedge and
  // released at the following negedge, where the pulse is visible.
  task automatic press(input logic m, input logic s);
    mode_btn = m;
    set_btn  = s;
    @(negedge clk);
    mode_btn = 1'b0;
    set_btn  = 1'b0;
    $display("[%0t] press mode=%b set=%b -> mode_pulse=%b set_pulse=%b en=%b sw=%h/%h",
             $time, m, s, bus1.mode_pulse, bus1.set_pulse, en1, d1, d2);
  endtask

  task automatic test_reset;
    rst = 1'b0; mode_btn = 1'b1; set_btn = 1'b0; setting_done = 1'b0;
    #12;
    n_cmp++; if (en1 !== 4'b1000) begin n_bad++; $display("FAIL reset_en: got %b expected 1000", en1); end
    n_cmp++; if ({bus1.mode_pulse, bus1.set_pulse, bus1.sw_running} !== 3'b000) begin
      n_bad++; $display("FAIL reset_pulses_run: got %b expected 000", {bus1.mode_pulse, bus1.set_pulse, bus1.sw_running}); end
    n_cmp++; if (d1 !== 16'h0000) begin n_bad++; $display("FAIL reset_digits: got %h expected 0000", d1); end
    @(negedge clk);
    rst = 1'b1;
    $display("[%0t] reset released with mode_btn held", $time);
  endtask

  task automatic test_held_button;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (bus1.mode_pulse !== 1'b0) begin n_bad++; $display("FAIL held_no_pulse[%0d]: got %b expected 0", i, bus1.mode_pulse); end
    end
    mode_btn = 1'b0;
    @(negedge clk); @(negedge clk);
    press(1'b1, 1'b0);
    n_cmp++; if (bus1.mode_pulse !== 1'b1) begin n_bad++; $display("FAIL repress_pulse: got %b expected 1", bus1.mode_pulse); end
    n_cmp++; if (en1 !== 4'b1000) begin n_bad++; $display("FAIL pulse_cycle_en: got %b expected 1000", en1); end
    @(negedge clk);
    n_cmp++; if (bus1.mode_pulse !== 1'b0) begin n_bad++; $display("FAIL pulse_width: got %b expected 0", bus1.mode_pulse); end
    n_cmp++; if (en1 !== 4'b0100) begin n_bad++; $display("FAIL enter_set_time: got %b expected 0100", en1); end
  endtask

  task automatic test_set_time;
    setting_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      press(1'b1, 1'b0);
      @(negedge clk);
      n_cmp++; if (en1 !== 4'b0100) begin n_bad++; $display("FAIL set_time_hold[%0d]: got %b expected 0100", i, en1); end
    end
    press(1'b0, 1'b1);
    n_cmp++; if (bus1.set_pulse !== 1'b1) begin n_bad++; $display("FAIL set_pulse: got %b expected 1", bus1.set_pulse); end
    @(negedge clk);
    n_cmp++; if (en1 !== 4'b0100) begin n_bad++; $display("FAIL set_no_state_change: got %b expected 0100", en1); end
    setting_done = 1'b1;
    @(negedge clk);
    press(1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (en1 !== 4'b0010) begin n_bad++; $display("FAIL enter_set_alarm: got %b expected 0010", en1); end
  endtask

  task automatic test_set_alarm;
    setting_done = 1'b0;
    @(negedge clk);
    press(1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (en1 !== 4'b0010) begin n_bad++; $display("FAIL alarm_hold: got %b expected 0010", en1); end
    setting_done = 1'b1;
    press(1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (en1 !== 4'b1001) begin n_bad++; $display("FAIL enter_stopwatch: got %b expected 1001", en1); end
    n_cmp++; if ({bus1.sw_running, d1} !== 17'h0_0000) begin n_bad++; $display("FAIL stopwatch_entry: got %h expected 00000", {bus1.sw_running, d1}); end
  endtask

  task automatic test_stopwatch_run;
    press(1'b0, 1'b1);
    repeat (124) @(negedge clk);
    press(1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (d1 !== 16'h0205) begin n_bad++; $display("FAIL run125_digits: got %h expected 0205", d1); end
    n_cmp++; if (d2 !== 16'h0005) begin n_bad++; $display("FAIL run125_short_digits: got %h expected 0005", d2); end
    n_cmp++; if (bus1.sw_running !== 1'b0) begin n_bad++; $display("FAIL run125_stopped: got %b expected 0", bus1.sw_running); end
    repeat (10) @(negedge clk);
    n_cmp++; if (d1 !== 16'h0205) begin n_bad++; $display("FAIL stopped_hold: got %h expected 0205", d1); end
  endtask

  task automatic test_reenter;
    press(1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (en1 !== 4'b1000) begin n_bad++; $display("FAIL leave_stopwatch: got %b expected 1000", en1); end
    n_cmp++; if (d1 !== 16'h0205) begin n_bad++; $display("FAIL digits_kept: got %h expected 0205", d1); end
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0);
      @(negedge clk);
    end
    n_cmp++; if (en1 !== 4'b1001) begin n_bad++; $display("FAIL reenter_stopwatch: got %b expected 1001", en1); end
    n_cmp++; if ({d1, d2} !== 32'h0) begin n_bad++; $display("FAIL reentry_clear: got %h expected 00000000", {d1, d2}); end
  endtask

  task automatic test_wrap;
    press(1'b0, 1'b1);
    repeat (120) @(negedge clk);
    n_cmp++; if (d2 !== 16'h0159) begin n_bad++; $display("FAIL wrap_pre: got %h expected 0159", d2); end
    n_cmp++; if (d1 !== 16'h0159) begin n_bad++; $display("FAIL count119: got %h expected 0159", d1); end
    @(negedge clk);
    n_cmp++; if ({bus2.sw_running, d2} !== 17'h1_0000) begin n_bad++; $display("FAIL wrap_zero: got %h expected 10000", {bus2.sw_running, d2}); end
    n_cmp++; if (d1 !== 16'h0200) begin n_bad++; $display("FAIL count120: got %h expected 0200", d1); end
    @(negedge clk);
    n_cmp++; if (d2 !== 16'h0001) begin n_bad++; $display("FAIL wrap_continue: got %h expected 0001", d2); end
  endtask

  task automatic test_simultaneous;
    press(1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (en1 !== 4'b1000) begin n_bad++; $display("FAIL both_state: got %b expected 1000", en1); end
    n_cmp++; if ({bus1.sw_running, bus2.sw_running} !== 2'b00) begin n_bad++; $display("FAIL both_running: got %b expected 00", {bus1.sw_running, bus2.sw_running}); end
    n_cmp++; if ({d1, d2} !== 32'h0203_0003) begin n_bad++; $display("FAIL both_digits: got %h expected 02030003", {d1, d2}); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({d1, d2} !== 32'h0203_0003) begin n_bad++; $display("FAIL both_hold: got %h expected 02030003", {d1, d2}); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0);
      @(negedge clk);
    end
    press(1'b0, 1'b1);
    repeat (5) @(negedge clk);
    n_cmp++; if ({en1, bus1.sw_running} !== 5'b10011) begin n_bad++; $display("FAIL pre_reset_running: got %b expected 10011", {en1, bus1.sw_running}); end
    mode_btn = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({en1, bus1.sw_running, d1} !== {5'b10000, 16'h0000}) begin
      n_bad++; $display("FAIL mid_reset: got %b/%h expected 10000/0000", {en1, bus1.sw_running}, d1); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus1.mode_pulse, en1} !== 5'b01000) begin n_bad++; $display("FAIL held_after_reset: got %b expected 01000", {bus1.mode_pulse, en1}); end
    mode_btn = 1'b0;
    @(negedge clk);
    press(1'b1, 1'b0);
    n_cmp++; if (bus1.mode_pulse !== 1'b1) begin n_bad++; $display("FAIL repress_after_reset: got %b expected 1", bus1.mode_pulse); end
  endtask

  initial begin
    test_reset;
    test_held_button;
    test_set_time;
    test_set_alarm;
    test_stopwatch_run;
    test_reenter;
    test_wrap;
    test_simultaneous;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
